// File: rtl/fft_pkg.sv
// Shared FFT datapath package: common data width and an elaboration-time
// ceiling-log2 helper used to size pointers and check configuration widths.
package fft_pkg;

    localparam int FFT_DATA_W = 16;

    // Ceiling log2, with a minimum result of 1 so that single-entry
    // structures still get a one-bit address.
    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        if (res == 0) res = 1;
        return res;
    endfunction

endpackage

// File: rtl/dly_ram_sdp.sv
// Simple dual-port RAM for the delay line: one synchronous write port and
// one registered synchronous read port. Contents are never reset.
module dly_ram_sdp #(
    parameter int W     = 17,
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port: store the incoming word on every enabled edge.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Read port: registered output, held when the read is not enabled.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/var_delay_line.sv
// Runtime-configurable, stallable delay line with a valid tag travelling
// alongside the data. Samples live in a circular RAM buffer; a delay of one
// bypasses the RAM through a single register. Outputs stay masked to zero
// until the line has absorbed D advances since the last clear or reset.
module var_delay_line
    import fft_pkg::*;
#(
    parameter int WIDTH     = FFT_DATA_W,
    parameter int MAX_DEPTH = 64,
    parameter int DEPTH_W   = 7,
    parameter int DEF_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic [DEPTH_W-1:0] depth_cfg,
    input  logic [WIDTH-1:0]   d_in,
    input  logic               vld_in,
    output logic [WIDTH-1:0]   d_out,
    output logic               vld_out,
    output logic               primed,
    output logic               cfg_err
);

    localparam int AW = clog2(MAX_DEPTH);
    localparam int RW = WIDTH + 1;

    // Configuration sanity checks, raised at elaboration time.
    if (MAX_DEPTH < 2) begin : g_bad_max
        $error("var_delay_line: MAX_DEPTH must be at least 2");
    end
    if (DEF_DEPTH < 1 || DEF_DEPTH > MAX_DEPTH) begin : g_bad_def
        $error("var_delay_line: DEF_DEPTH must lie in 1..MAX_DEPTH");
    end
    if (clog2(MAX_DEPTH + 1) > DEPTH_W) begin : g_bad_dw
        $error("var_delay_line: DEPTH_W too narrow to encode MAX_DEPTH");
    end

    // Clamp a requested delay into the legal 1..MAX_DEPTH range.
    function automatic logic [DEPTH_W-1:0] sat_depth(input logic [DEPTH_W-1:0] req);
        if (req == '0) return DEPTH_W'(1);
        if (req > DEPTH_W'(MAX_DEPTH)) return DEPTH_W'(MAX_DEPTH);
        return req;
    endfunction

    // A requested delay outside 1..MAX_DEPTH is flagged as a config error.
    function automatic logic depth_illegal(input logic [DEPTH_W-1:0] req);
        return (req == '0) || (req > DEPTH_W'(MAX_DEPTH));
    endfunction

    logic               adv;
    logic               byp_sel;
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_addr;
    logic [DEPTH_W:0]   rd_sum;
    logic [DEPTH_W-1:0] depth_q;
    logic [DEPTH_W-1:0] fill;
    logic [DEPTH_W-1:0] fill_nxt;
    logic [RW-1:0]      word_p0;
    logic [RW-1:0]      byp_p1;
    logic [RW-1:0]      ram_p1;
    logic [RW-1:0]      word_p1;

    assign adv     = en & ~clr;
    assign byp_sel = (depth_q == DEPTH_W'(1));
    assign word_p0 = {vld_in, d_in};

    // Saturating advance count; it stops at the configured delay.
    assign fill_nxt = (fill == depth_q) ? fill : fill + DEPTH_W'(1);

    // Read address trails the write pointer by D-1 slots, modulo MAX_DEPTH.
    always_comb begin
        rd_sum  = (DEPTH_W+1)'(wr_ptr) + (DEPTH_W+1)'(MAX_DEPTH + 1)
                - (DEPTH_W+1)'(depth_q);
        rd_addr = (rd_sum >= (DEPTH_W+1)'(MAX_DEPTH))
                ? AW'(rd_sum - (DEPTH_W+1)'(MAX_DEPTH))
                : AW'(rd_sum);
    end

    // Control state: write pointer, fill count, priming, depth and error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            fill    <= '0;
            primed  <= 1'b0;
            depth_q <= DEPTH_W'(DEF_DEPTH);
            cfg_err <= 1'b0;
        end else if (clr) begin
            wr_ptr  <= '0;
            fill    <= '0;
            primed  <= 1'b0;
            depth_q <= sat_depth(depth_cfg);
            cfg_err <= depth_illegal(depth_cfg);
        end else if (en) begin
            wr_ptr  <= (wr_ptr == AW'(MAX_DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            fill    <= fill_nxt;
            primed  <= (fill_nxt == depth_q);
        end
    end

    // ---- stage p0 -> p1: RAM write/read and single-register bypass ----
    dly_ram_sdp #(
        .W     (RW),
        .DEPTH (MAX_DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (adv),
        .waddr (wr_ptr),
        .wdata (word_p0),
        .re    (adv & ~byp_sel),
        .raddr (rd_addr),
        .rdata (ram_p1)
    );

    // Bypass register used when the delay is a single advance.
    always_ff @(posedge clk) begin
        if (adv) byp_p1 <= word_p0;
    end

    // Output select and masking: nothing reaches the outputs until primed.
    always_comb begin
        word_p1 = byp_sel ? byp_p1 : ram_p1;
        d_out   = primed ? word_p1[WIDTH-1:0] : '0;
        vld_out = primed & word_p1[WIDTH];
    end

endmodule
